// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int   UART_OVERSAMPLE_DEF = 16;
    localparam int   UART_DATA_BITS_DEF  = 8;
    localparam logic UART_IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: emits one tick every DIV clocks; clr holds the phase at zero.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = !clr && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1) with sticky recv_flag/overrun handshake.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       clean_recv_flag,
    output logic [7:0] dout,
    output logic       rfin,
    output logic       recv_flag,
    output logic       overrun,
    output logic       frame_err
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int SC_W    = $clog2(OVERSAMPLE);
    localparam int BI_W    = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

    uart_rx_state_t        state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rxs_q, rxs_d;
    logic [SC_W-1:0]       sc_q, sc_d;
    logic [BI_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [7:0]            dout_q, dout_d;
    logic                  rfin_q, rfin_d;
    logic                  recv_q, recv_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  tick;
    logic                  parity_ok;
    logic [7:0]            shreg_ext;

    assign shreg_ext = 8'(shreg_q);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign parity_ok = ~(^{shreg_q, par_q});
`else
    assign parity_ok = 1'b1;
`endif

    // Holding the divider in IDLE aligns every tick to the detected start edge.
    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .tick(tick)
    );

    always_comb begin
        sync1_d     = rxd;
        rxs_d       = sync1_q;
        state_d     = state_q;
        sc_d        = sc_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        rfin_d      = 1'b0;
        frame_err_d = 1'b0;
        recv_d      = recv_q;
        overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
`endif

        // Clear first so a byte completing in the same cycle still sets the flag.
        if (clean_recv_flag) begin
            recv_d    = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    sc_d    = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sc_q == SC_HALF) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            sc_d      = '0;
                            bit_idx_d = '0;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        sc_d    = '0;
                        if (bit_idx_q == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        par_d   = rxs_q;
                        sc_d    = '0;
                        state_d = STOP;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (rxs_q && parity_ok) begin
                            dout_d    = shreg_ext;
                            rfin_d    = 1'b1;
                            overrun_d = overrun_d | (recv_q & ~clean_recv_flag);
                            recv_d    = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync1_q     <= UART_IDLE_LEVEL;
            rxs_q       <= UART_IDLE_LEVEL;
            sc_q        <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            rfin_q      <= 1'b0;
            recv_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            sc_q        <= sc_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            rfin_q      <= rfin_d;
            recv_q      <= recv_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign rfin      = rfin_q;
    assign recv_flag = recv_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed vector table, reset/parity sequences
// and randomized frames checked against a flag-level reference model.
module tb_uart_rx_oversample;

    localparam int CLK_FREQ   = 6_400_000;
    localparam int BAUD       = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int BIT_CYC    = DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LATENCY = 2 + DIV * (OVERSAMPLE / 2 + (DATA_BITS + 1 + PAR_BITS) * OVERSAMPLE) + 1;

    localparam int OP_FRAME  = 0;
    localparam int OP_CLEAN  = 1;
    localparam int OP_GLITCH = 2;

    typedef struct {
        int         op;
        logic [7:0] data;
        logic       stop_good;
        logic       clean_at_done;
        logic [7:0] exp_dout;
        logic       exp_recv;
        logic       exp_ov;
        int         exp_rfin;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       clean_recv_flag = 1'b0;
    logic [7:0] dout;
    logic       rfin;
    logic       recv_flag;
    logic       overrun;
    logic       frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int rfin_cnt = 0;
    int ferr_cnt = 0;
    int rfin_cyc = 0;

    uart_rx_oversample #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rxd            (rxd),
        .clean_recv_flag(clean_recv_flag),
        .dout           (dout),
        .rfin           (rfin),
        .recv_flag      (recv_flag),
        .overrun        (overrun),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse outputs are counted on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rfin) begin
            rfin_cnt = rfin_cnt + 1;
            rfin_cyc = cyc;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd = 1'b1;
            clean_recv_flag = 1'b0;
        end
    endtask

    task automatic pulse_clean();
        @(negedge clk);
        clean_recv_flag = 1'b1;
        @(negedge clk);
        clean_recv_flag = 1'b0;
        idle_cycles(4);
    endtask

    // Drives one full frame; a bad stop bit holds the line low for two bit-times then one bit high.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_good, input logic par_flip,
                                  input logic clean_at_done, output int t0);
        int   nbits;
        int   total;
        int   b;
        logic par;
        par   = (^data) ^ par_flip;
        nbits = 1 + DATA_BITS + PAR_BITS + 1;
        total = stop_good ? nbits * BIT_CYC : (nbits + 2) * BIT_CYC;
        t0    = 0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i == 0) t0 = cyc;
            b = i / BIT_CYC;
            if (b == 0)                                  rxd = 1'b0;
            else if (b <= DATA_BITS)                     rxd = data[b-1];
            else if (PAR_BITS == 1 && b == DATA_BITS + 1) rxd = par;
            else if (stop_good)                          rxd = 1'b1;
            else                                         rxd = (b >= nbits + 1);
            clean_recv_flag = clean_at_done && (i == LATENCY - 1);
        end
    endtask

    vec_t vecs[9];
    logic [7:0] m_dout;
    logic       m_recv;
    logic       m_ov;

    initial begin
        int         r0, f0, t0;
        logic [7:0] d;
        logic       sg, cb;

        vecs[0] = '{OP_FRAME,  8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{OP_GLITCH, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{OP_FRAME,  8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{OP_CLEAN,  8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 0, 0};
        vecs[4] = '{OP_FRAME,  8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1, 0};
        vecs[5] = '{OP_FRAME,  8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1, 0};
        vecs[6] = '{OP_CLEAN,  8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 0, 0};
        vecs[7] = '{OP_FRAME,  8'h66, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1, 0};
        vecs[8] = '{OP_FRAME,  8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1, 0};

        idle_cycles(3);
        check_output("reset_dout", dout, 8'h00);
        check_output("reset_rfin", rfin, 1'b0);
        check_output("reset_recv", recv_flag, 1'b0);
        check_output("reset_overrun", overrun, 1'b0);
        check_output("reset_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        idle_cycles(BIT_CYC);

        for (int i = 0; i < 9; i++) begin
            r0 = rfin_cnt;
            f0 = ferr_cnt;
            t0 = 0;
            case (vecs[i].op)
                OP_FRAME: apply_stimulus(vecs[i].data, vecs[i].stop_good, 1'b0, vecs[i].clean_at_done, t0);
                OP_CLEAN: pulse_clean();
                default: begin
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        rxd = 1'b0;
                    end
                    idle_cycles(3 * BIT_CYC);
                end
            endcase
            idle_cycles(2);
            check_output($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            check_output($sformatf("v%0d_recv", i), recv_flag, vecs[i].exp_recv);
            check_output($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ov);
            check_output($sformatf("v%0d_rfin_count", i), rfin_cnt - r0, vecs[i].exp_rfin);
            check_output($sformatf("v%0d_ferr_count", i), ferr_cnt - f0, vecs[i].exp_ferr);
            if (vecs[i].exp_rfin == 1) begin
                check_output($sformatf("v%0d_latency", i), rfin_cyc - t0, LATENCY);
            end
        end

        // Reset dropped in the middle of the data bits of 0xFF.
        for (int i = 0; i < 4 * BIT_CYC; i++) begin
            @(negedge clk);
            rxd = (i < BIT_CYC) ? 1'b0 : 1'b1;
        end
        rst = 1'b0;
        idle_cycles(3);
        check_output("midreset_dout", dout, 8'h00);
        check_output("midreset_rfin", rfin, 1'b0);
        check_output("midreset_recv", recv_flag, 1'b0);
        check_output("midreset_overrun", overrun, 1'b0);
        check_output("midreset_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        idle_cycles(2 * BIT_CYC);
        r0 = rfin_cnt;
        apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b0, t0);
        idle_cycles(2);
        check_output("after_reset_dout", dout, 8'h5A);
        check_output("after_reset_recv", recv_flag, 1'b1);
        check_output("after_reset_rfin_count", rfin_cnt - r0, 1);
        m_dout = 8'h5A;
        m_recv = 1'b1;
        m_ov   = 1'b0;

`ifdef UART_RX_PARITY_EN
        r0 = rfin_cnt;
        f0 = ferr_cnt;
        apply_stimulus(8'h5A, 1'b1, 1'b1, 1'b0, t0);
        idle_cycles(2);
        check_output("bad_parity_ferr_count", ferr_cnt - f0, 1);
        check_output("bad_parity_rfin_count", rfin_cnt - r0, 0);
        check_output("bad_parity_dout", dout, 8'h5A);
        idle_cycles(BIT_CYC);
`endif

        // Randomized frames against the flag-level model.
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            cb = 1'($urandom % 2);
            sg = ($urandom % 5) != 0;
            if (cb) begin
                pulse_clean();
                m_recv = 1'b0;
                m_ov   = 1'b0;
            end
            r0 = rfin_cnt;
            f0 = ferr_cnt;
            apply_stimulus(d, sg, 1'b0, 1'b0, t0);
            if (sg) begin
                if (m_recv) m_ov = 1'b1;
                m_recv = 1'b1;
                m_dout = d;
            end
            idle_cycles(2);
            check_output($sformatf("rnd%0d_dout", n), dout, m_dout);
            check_output($sformatf("rnd%0d_recv", n), recv_flag, m_recv);
            check_output($sformatf("rnd%0d_overrun", n), overrun, m_ov);
            check_output($sformatf("rnd%0d_rfin_count", n), rfin_cnt - r0, sg ? 1 : 0);
            check_output($sformatf("rnd%0d_ferr_count", n), ferr_cnt - f0, sg ? 0 : 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
